// File: rtl/async_fifo_pkg.sv
// Helpers shared by the read and write pointer controllers of the async FIFO.
// Pointer width and the Gray-pointer full-comparison mask live here.
package async_fifo_pkg;

  // Pointer width for a given depth; the extra MSB is the wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Gray pointers are full when the top two bits differ and the rest match.
  function automatic logic [31:0] full_mask(input int w);
    return 32'd3 << (w - 2);
  endfunction

endpackage

// File: rtl/BinToGray.sv
// Binary to reflected Gray code conversion.
module BinToGray #(
  parameter int p_bit_width = 4
) (
  input  logic [p_bit_width-1:0] bin,
  output logic [p_bit_width-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/GrayToBin.sv
// Gray to binary conversion: each binary bit is the XOR of all Gray bits at or above it.
module GrayToBin #(
  parameter int p_bit_width = 4
) (
  input  logic [p_bit_width-1:0] gray,
  output logic [p_bit_width-1:0] bin
);

  for (genvar i = 0; i < p_bit_width; i++) begin : g_bit
    assign bin[i] = ^gray[p_bit_width-1:i];
  end

endmodule

// File: rtl/ResetSync.sv
// Reset synchronizer: asserts asynchronously, deasserts after two clk edges.
module ResetSync (
  input  logic clk,
  input  logic async_rst,
  output logic reset
);

  logic [1:0] rst_pipe;

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) rst_pipe <= 2'b11;
    else           rst_pipe <= {rst_pipe[0], 1'b0};
  end

  assign reset = rst_pipe[1];

endmodule

// File: rtl/Synchronizer.sv
// Two-flop multi-bit synchronizer for a Gray-coded bus, reset to zero.
module Synchronizer #(
  parameter int p_bit_width = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [p_bit_width-1:0] d,
  output logic [p_bit_width-1:0] q
);

  logic [1:0][p_bit_width-1:0] sync_pipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_pipe <= '0;
    else       sync_pipe <= {sync_pipe[0], d};
  end

  assign q = sync_pipe[1];

endmodule

// File: rtl/async_fifo_write_ctrl.sv
// Write-side pointer controller of the async FIFO: write pointers, read-pointer
// synchronization, full / almost-full / occupancy and a sticky overflow flag.
module async_fifo_write_ctrl
  import async_fifo_pkg::*;
#(
  parameter int p_num_entries        = 8,
  parameter int p_ptr_width          = ptr_width(p_num_entries),
  parameter int p_almost_full_thresh = p_num_entries - 1
) (
  input  logic                   clk,
  input  logic                   async_rst,
  input  logic                   w_en,
  input  logic [p_ptr_width-1:0] g_read_ptr_async,
  input  logic                   clr_overflow,
  output logic                   mem_w_en,
  output logic [p_ptr_width-2:0] w_addr,
  output logic [p_ptr_width-1:0] b_write_ptr,
  output logic [p_ptr_width-1:0] g_write_ptr,
  output logic                   full,
  output logic                   almost_full,
  output logic [p_ptr_width-1:0] count,
  output logic                   overflow
);

  localparam logic [31:0]            FULL_MASK32 = full_mask(p_ptr_width);
  localparam logic [p_ptr_width-1:0] FULL_MASK   = FULL_MASK32[p_ptr_width-1:0];
  localparam logic [p_ptr_width-1:0] AF_THRESH   = p_ptr_width'(p_almost_full_thresh);

  logic                   reset;
  logic [p_ptr_width-1:0] g_rptr_s;
  logic [p_ptr_width-1:0] b_rptr_s;
  logic [p_ptr_width-1:0] b_next;
  logic [p_ptr_width-1:0] g_next;

  ResetSync u_reset_sync (
    .clk       (clk),
    .async_rst (async_rst),
    .reset     (reset)
  );

  Synchronizer #(.p_bit_width(p_ptr_width)) u_rptr_sync (
    .clk   (clk),
    .reset (reset),
    .d     (g_read_ptr_async),
    .q     (g_rptr_s)
  );

  GrayToBin #(.p_bit_width(p_ptr_width)) u_rptr_g2b (
    .gray (g_rptr_s),
    .bin  (b_rptr_s)
  );

  BinToGray #(.p_bit_width(p_ptr_width)) u_wptr_b2g (
    .bin  (b_next),
    .gray (g_next)
  );

  // full includes reset, so no write is accepted on an edge that reset covers.
  assign mem_w_en = w_en && !full;
  assign w_addr   = b_write_ptr[p_ptr_width-2:0];
  assign b_next   = b_write_ptr + p_ptr_width'(mem_w_en);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_write_ptr <= '0;
      g_write_ptr <= '0;
    end else begin
      b_write_ptr <= b_next;
      g_write_ptr <= g_next;
    end
  end

  // Registers only on these paths; the synchronized read pointer lags, so full is pessimistic.
  assign full        = reset || (g_write_ptr == (g_rptr_s ^ FULL_MASK));
  assign count       = b_write_ptr - b_rptr_s;
  assign almost_full = reset || (count >= AF_THRESH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              overflow <= 1'b0;
    else if (w_en && full)  overflow <= 1'b1;
    else if (clr_overflow)  overflow <= 1'b0;
  end

endmodule

// File: tb/tb_async_fifo_write_ctrl.sv
// Directed bench for the async FIFO write-side controller at depth 8.
module tb_async_fifo_write_ctrl;

  logic       clk = 1'b0;
  logic       async_rst = 1'b0;
  logic       w_en = 1'b0;
  logic [3:0] g_read_ptr_async = '0;
  logic       clr_overflow = 1'b0;
  logic       mem_w_en;
  logic [2:0] w_addr;
  logic [3:0] b_write_ptr;
  logic [3:0] g_write_ptr;
  logic       full;
  logic       almost_full;
  logic [3:0] count;
  logic       overflow;

  int n_vec = 0;
  int n_err = 0;

  async_fifo_write_ctrl #(.p_num_entries(8)) dut (
    .clk              (clk),
    .async_rst        (async_rst),
    .w_en             (w_en),
    .g_read_ptr_async (g_read_ptr_async),
    .clr_overflow     (clr_overflow),
    .mem_w_en         (mem_w_en),
    .w_addr           (w_addr),
    .b_write_ptr      (b_write_ptr),
    .g_write_ptr      (g_write_ptr),
    .full             (full),
    .almost_full      (almost_full),
    .count            (count),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 async_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    w_en = 1'b1;
    #1;
    n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL rst_full: got %b want 1", full); end
    n_vec++; if (almost_full !== 1'b1) begin n_err++; $display("FAIL rst_almost_full: got %b want 1", almost_full); end
    n_vec++; if (b_write_ptr !== 4'd0 || g_write_ptr !== 4'd0) begin n_err++; $display("FAIL rst_ptrs: got b=%0d g=%0d want 0 0", b_write_ptr, g_write_ptr); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    n_vec++; if (mem_w_en !== 1'b0) begin n_err++; $display("FAIL rst_mem_w_en: got %b want 0", mem_w_en); end
    n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", count); end
    w_en = 1'b0;
    async_rst = 1'b0;
    tick();
    n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL rst_release_edge1_full: got %b want 1", full); end
    tick();
    n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL rst_release_full: got %b want 0", full); end
    n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL rst_release_count: got %0d want 0", count); end
  endtask

  // Eight writes with the read pointer at zero; almost_full expected from count 7.
  task automatic test_fill_almost_full();
    for (int i = 0; i < 8; i++) begin
      w_en = 1'b1;
      #1;
      n_vec++; if (mem_w_en !== 1'b1) begin n_err++; $display("FAIL fill_mem_w_en[%0d]: got %b want 1", i, mem_w_en); end
      n_vec++; if (w_addr !== 3'(i)) begin n_err++; $display("FAIL fill_w_addr[%0d]: got %0d want %0d", i, w_addr, i); end
      @(posedge clk); #1;
      w_en = 1'b0;
      n_vec++; if (count !== 4'(i + 1)) begin n_err++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1); end
      n_vec++; if (almost_full !== (i + 1 >= 7)) begin n_err++; $display("FAIL almost_full[%0d]: got %b want %b", i, almost_full, (i + 1 >= 7)); end
      n_vec++; if (full !== (i == 7)) begin n_err++; $display("FAIL fill_full[%0d]: got %b want %b", i, full, (i == 7)); end
    end
    n_vec++; if (g_write_ptr !== 4'b1100) begin n_err++; $display("FAIL fill_gray: got %b want 1100", g_write_ptr); end
    w_en = 1'b1;
    #1;
    n_vec++; if (mem_w_en !== 1'b0) begin n_err++; $display("FAIL ninth_mem_w_en: got %b want 0", mem_w_en); end
    tick();
    w_en = 1'b0;
    n_vec++; if (b_write_ptr !== 4'd8) begin n_err++; $display("FAIL ninth_b_ptr: got %0d want 8", b_write_ptr); end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ninth_overflow: got %b want 1", overflow); end
  endtask

  task automatic test_overflow_clear();
    w_en = 1'b1; clr_overflow = 1'b1;
    tick();
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set_wins_hold: got %b want 1", overflow); end
    w_en = 1'b0;
    tick();
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    w_en = 1'b1;
    tick();
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set_wins_rise: got %b want 1", overflow); end
    w_en = 1'b0;
    tick();
    clr_overflow = 1'b0;
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear2: got %b want 0", overflow); end
  endtask

  task automatic test_drain_wrap();
    g_read_ptr_async = 4'b0010;  // Gray(3)
    tick();
    n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL drain_edge1_full: got %b want 1", full); end
    tick();
    n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL drain_full: got %b want 0", full); end
    n_vec++; if (count !== 4'd5) begin n_err++; $display("FAIL drain_count: got %0d want 5", count); end
    for (int i = 0; i < 3; i++) begin
      w_en = 1'b1;
      #1;
      n_vec++; if (w_addr !== 3'(i)) begin n_err++; $display("FAIL wrap_w_addr[%0d]: got %0d want %0d", i, w_addr, i); end
      @(posedge clk); #1;
      w_en = 1'b0;
    end
    n_vec++; if (b_write_ptr !== 4'd11) begin n_err++; $display("FAIL wrap_b_ptr: got %0d want 11", b_write_ptr); end
    n_vec++; if (g_write_ptr !== 4'b1110) begin n_err++; $display("FAIL wrap_g_ptr: got %b want 1110", g_write_ptr); end
    n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL wrap_full: got %b want 1", full); end
    n_vec++; if (count !== 4'd8) begin n_err++; $display("FAIL wrap_count: got %0d want 8", count); end
  endtask

  task automatic test_reset_mid_burst();
    g_read_ptr_async = 4'b0101;  // Gray(6): count 11-6 = 5
    tick(); tick();
    n_vec++; if (count !== 4'd5) begin n_err++; $display("FAIL mid_pre_count: got %0d want 5", count); end
    w_en = 1'b1;
    #1;
    n_vec++; if (mem_w_en !== 1'b1) begin n_err++; $display("FAIL mid_pre_mem_w_en: got %b want 1", mem_w_en); end
    async_rst = 1'b1;
    #1;
    n_vec++; if (full !== 1'b1 || almost_full !== 1'b1) begin n_err++; $display("FAIL mid_rst_flags: got full=%b af=%b want 1 1", full, almost_full); end
    n_vec++; if (b_write_ptr !== 4'd0 || g_write_ptr !== 4'd0 || count !== 4'd0) begin n_err++; $display("FAIL mid_rst_ptrs: got b=%0d g=%0d cnt=%0d want 0 0 0", b_write_ptr, g_write_ptr, count); end
    n_vec++; if (mem_w_en !== 1'b0) begin n_err++; $display("FAIL mid_rst_mem_w_en: got %b want 0", mem_w_en); end
    g_read_ptr_async = 4'b0000;
    tick();
    n_vec++; if (b_write_ptr !== 4'd0) begin n_err++; $display("FAIL mid_dropped_write: got %0d want 0", b_write_ptr); end
    w_en = 1'b0;
    async_rst = 1'b0;
    tick(); tick();
    n_vec++; if (full !== 1'b0 || count !== 4'd0) begin n_err++; $display("FAIL mid_resync: got full=%b cnt=%0d want 0 0", full, count); end
    w_en = 1'b1;
    #1;
    n_vec++; if (mem_w_en !== 1'b1 || w_addr !== 3'd0) begin n_err++; $display("FAIL mid_first_write: got en=%b addr=%0d want 1 0", mem_w_en, w_addr); end
    tick();
    w_en = 1'b0;
    n_vec++; if (b_write_ptr !== 4'd1 || count !== 4'd1) begin n_err++; $display("FAIL mid_after_write: got b=%0d cnt=%0d want 1 1", b_write_ptr, count); end
  endtask

  initial begin
    test_reset();
    test_fill_almost_full();
    test_overflow_clear();
    test_drain_wrap();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/async_fifo_write_ctrl.md
# async_fifo_write_ctrl

Write-side pointer controller for the async FIFO, the counterpart of the read-pointer handler. It lives entirely in the write clock domain and tracks the binary and Gray write pointers. It synchronizes the Gray read pointer from the read domain and generates full, almost-full, occupancy and a sticky overflow flag. It also drives the write address and write strobe of the shared dual-port FIFO memory.

## Interface
Parameters:
- p_num_entries, 8: FIFO depth; power of two, ≥ 2.
- p_ptr_width, $clog2(p_num_entries)+1: pointer width; the extra MSB is the wrap bit.
- p_almost_full_thresh, p_num_entries-1: occupancy at or above which almost_full asserts; range 1..p_num_entries.

Ports:
- clk  in  1  write-domain clock.
- async_rst  in  1  reset; **asynchronous, active-high**, internally reset-synchronized.
- w_en  in  1  producer write request.
- g_read_ptr_async  in  p_ptr_width  Gray read pointer from the read domain (unsynchronized).
- clr_overflow  in  1  clears the overflow flag.
- mem_w_en  out  1  memory write strobe.
- w_addr  out  p_ptr_width-1  memory write address.
- b_write_ptr  out  p_ptr_width  binary write pointer.
- g_write_ptr  out  p_ptr_width  Gray write pointer (registered, to the read domain).
- full  out  1  FIFO full.
- almost_full  out  1  occupancy ≥ p_almost_full_thresh.
- count  out  p_ptr_width  write-side occupancy estimate, 0..p_num_entries.
- overflow  out  1  sticky: a write was attempted while full.

## Operation
- Internal reset: ResetSync produces `reset`. It asserts asynchronously and deasserts after 2 clk edges.
- While `reset` is high:
  - b_write_ptr = g_write_ptr = 0, synchronized read pointer = 0, overflow = 0, count = 0.
  - full = 1 and almost_full = 1 (forced), so mem_w_en = 0.
- Read-pointer synchronization: a 2-flop Synchronizer (reset to 0) yields g_rptr_s. A GrayToBin conversion gives b_rptr_s.
- Write datapath:
  - mem_w_en = w_en && !full.
  - w_addr = b_write_ptr[p_ptr_width-2:0].
  - b_next = b_write_ptr + mem_w_en, modulo 2^p_ptr_width (wraps silently).
  - g_next = BinToGray(b_next).
  - Both pointers register on posedge clk.
- full = reset || (g_write_ptr == {~g_rptr_s[MSB:MSB-1], g_rptr_s[MSB-2:0]}). This is combinational from registers only.
- count = (b_write_ptr - b_rptr_s) mod 2^p_ptr_width. It never exceeds p_num_entries.
- almost_full = reset || (count ≥ p_almost_full_thresh).
- overflow is a register:
  - Set when w_en && full && !reset.
  - Otherwise cleared when clr_overflow.
  - Set wins over a simultaneous clr_overflow.
- Full is conservative: reads become visible only after synchronization, so full may remain high after the read side has freed space. It is never low while the FIFO is actually full.

## Timing
- A write is accepted on the rising edge where mem_w_en = 1; memory captures at w_addr on that same edge.
- b_write_ptr, g_write_ptr, count, full and almost_full reflect the accepted write the cycle after it.
- No combinational path from w_en to full, count or the pointers.
- A change on g_read_ptr_async affects g_rptr_s, count and full 2 clk edges later.
- g_write_ptr changes at most one bit per cycle.
- async_rst mid-operation:
  - Outputs return to reset values immediately.
  - An in-flight write on that edge is dropped.
  - Operation resumes 2 edges after deassertion.

## Structure
- Shared package async_fifo_pkg holds the pointer-width helper function and the full-comparison mask function, so the read and write sides share them.
- Reuse the existing ResetSync, Synchronizer and BinToGray modules.
- Add one new sub-module, GrayToBin, parameterized on p_bit_width: a purely combinational prefix XOR.

## Test plan
- **Reset:** hold async_rst 3 cycles, then release.
  - During reset: full = 1, almost_full = 1, pointers 0, overflow 0.
  - 2 edges after release: full = 0, count = 0.
- **Fill, depth 8, read pointer held at 0:** 8 consecutive w_en.
  - w_addr runs 0..7; count reaches 8; full = 1 after the 8th write.
  - A 9th w_en gives mem_w_en = 0, pointers unchanged, overflow = 1.
- **Almost-full, default threshold:** almost_full rises the cycle after the 7th write (count = 7).
- **Drain and wrap:**
  - From full, step g_read_ptr_async to Gray(3); full drops 2 cycles later and count = 5.
  - Write 3 more: b_write_ptr = 11 (wrap bit set), w_addr = 2, g_write_ptr = Gray(11), full = 1.
- **Overflow clear:**
  - clr_overflow alone → overflow = 0 next cycle.
  - clr_overflow together with a write while full → overflow stays 1.
- **Reset mid-burst:** assert async_rst while writing at count = 5.
  - All outputs reset immediately; the write on that edge is not counted.
  - After resync, the first write lands at w_addr 0.
